// File: rtl/ps2_scancode.sv
// PS/2 keyboard front end: synchronises and filters the raw PS/2 lines, deframes
// 11-bit frames and turns the byte stream into make/break key events for the matrix.
module ps2_scancode #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 4000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2ck,
  input  logic       ps2d,
  output logic       kstb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       perr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic              ck_meta_q, ck_meta_d, ck_sync_q, ck_sync_d;
  logic              d_meta_q, d_meta_d, d_sync_q, d_sync_d;
  logic [FILTER-1:0] filt_q, filt_d;
  logic              fck_q, fck_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        sr_q, sr_d;
  logic              par_q, par_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              byte_vld_q, byte_vld_d;
  logic              byte_err_q, byte_err_d;
  logic              extf_q, extf_d;
  logic              brkf_q, brkf_d;
  logic [2:0]        skip_q, skip_d;
  logic              kstb_q, kstb_d;
  logic              perr_q, perr_d;
  logic [7:0]        code_q, code_d;
  logic              make_q, make_d;
  logic              ext_q, ext_d;
  logic              fall_s;

  always_comb begin
    ck_meta_d  = ps2ck;
    ck_sync_d  = ck_meta_q;
    d_meta_d   = ps2d;
    d_sync_d   = d_meta_q;

    filt_d = ce ? {filt_q[FILTER-2:0], ck_sync_q} : filt_q;
    if (&filt_d) begin
      fck_d = 1'b1;
    end else if (~|filt_d) begin
      fck_d = 1'b0;
    end else begin
      fck_d = fck_q;
    end
    fall_s = fck_q & ~fck_d;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    byte_err_d = 1'b0;

    // The timeout counter only runs while a frame is in progress.
    if (state_q == S_IDLE || fall_s) begin
      tcnt_d = '0;
    end else if (ce) begin
      tcnt_d = tcnt_q + TW'(1);
    end else begin
      tcnt_d = tcnt_q;
    end

    if (fall_s) begin
      case (state_q)
        S_IDLE: begin
          if (!d_sync_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          sr_d      = {d_sync_q, sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PAR;
          end else begin
            state_d = S_DATA;
          end
        end
        S_PAR: begin
          par_d   = d_sync_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          byte_vld_d = 1'b1;
          byte_err_d = ~(d_sync_q & (^{sr_q, par_q}));
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && ce && tcnt_q == TMO_LAST) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
    end else begin
      state_d = state_q;
    end

    // Prefix stage: one cycle after the stop bit, sr_q still holds the byte.
    extf_d = extf_q;
    brkf_d = brkf_q;
    skip_d = skip_q;
    kstb_d = 1'b0;
    perr_d = 1'b0;
    code_d = code_q;
    make_d = make_q;
    ext_d  = ext_q;
    if (byte_vld_q) begin
      if (byte_err_q) begin
        perr_d = 1'b1;
        extf_d = 1'b0;
        brkf_d = 1'b0;
        skip_d = 3'd0;
      end else if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (sr_q)
          8'hE0: extf_d = 1'b1;
          8'hF0: brkf_d = 1'b1;
          8'hE1: begin
            skip_d = 3'd7;
            extf_d = 1'b0;
            brkf_d = 1'b0;
          end
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
            extf_d = 1'b0;
            brkf_d = 1'b0;
          end
          default: begin
            code_d = sr_q;
            make_d = brkf_q;
            ext_d  = extf_q;
            kstb_d = 1'b1;
            extf_d = 1'b0;
            brkf_d = 1'b0;
          end
        endcase
      end
    end else begin
      kstb_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ck_meta_q  <= 1'b1;
      ck_sync_q  <= 1'b1;
      d_meta_q   <= 1'b1;
      d_sync_q   <= 1'b1;
      filt_q     <= '1;
      fck_q      <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      sr_q       <= 8'h00;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      byte_vld_q <= 1'b0;
      byte_err_q <= 1'b0;
      extf_q     <= 1'b0;
      brkf_q     <= 1'b0;
      skip_q     <= 3'd0;
      kstb_q     <= 1'b0;
      perr_q     <= 1'b0;
      code_q     <= 8'h00;
      make_q     <= 1'b1;
      ext_q      <= 1'b0;
    end else begin
      ck_meta_q  <= ck_meta_d;
      ck_sync_q  <= ck_sync_d;
      d_meta_q   <= d_meta_d;
      d_sync_q   <= d_sync_d;
      filt_q     <= filt_d;
      fck_q      <= fck_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      byte_vld_q <= byte_vld_d;
      byte_err_q <= byte_err_d;
      extf_q     <= extf_d;
      brkf_q     <= brkf_d;
      skip_q     <= skip_d;
      kstb_q     <= kstb_d;
      perr_q     <= perr_d;
      code_q     <= code_d;
      make_q     <= make_d;
      ext_q      <= ext_d;
    end
  end

  assign kstb = kstb_q;
  assign perr = perr_q;
  assign code = code_q;
  assign make = make_q;
  assign ext  = ext_q;

endmodule

// File: tb/tb_ps2_scancode.sv
// Directed bench for ps2_scancode: drives PS/2 frames, predicts key events with an
// event-level model and checks every output on every cycle.
module tb_ps2_scancode;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 4000;
  localparam int HALF    = 30;
  localparam int TAIL    = 100;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       mk;
    logic       ex;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce    = 1'b0;
  logic       ps2ck = 1'b1;
  logic       ps2d  = 1'b1;
  logic       kstb, make, ext, perr;
  logic [7:0] code;

  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  logic [7:0] cur_code;
  logic cur_mk, cur_ex;
  logic m_ext, m_brk;
  int   m_skip;

  ps2_scancode #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2ck(ps2ck), .ps2d(ps2d),
    .kstb(kstb), .make(make), .code(code), .ext(ext), .perr(perr)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      @(negedge clock);
      ce = ~ce;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_code = 8'h00;
    cur_mk   = 1'b1;
    cur_ex   = 1'b0;
    m_ext    = 1'b0;
    m_brk    = 1'b0;
    m_skip   = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic good);
    ev_t e;
    if (!good) begin
      e.err = 1'b1; e.code = 8'h00; e.mk = 1'b0; e.ex = 1'b0;
      exp_q.push_back(e);
      m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip = m_skip - 1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      e.err = 1'b0; e.code = b; e.mk = m_brk; e.ex = m_ext;
      exp_q.push_back(e);
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      tick(HALF);
      ps2ck = 1'b0;
      tick(HALF);
      ps2ck = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    model_byte(b, !bad_par);
    send_bits({1'b1, par, b, 1'b0}, 11);
    ps2d = 1'b1;
    tick(TAIL);
    check("drained", exp_q.size(), 0);
  endtask

  task automatic compare_loop();
    ev_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (kstb || perr) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", {30'd0, kstb, perr}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("kstb", kstb, !e.err);
            check("perr", perr, e.err);
            if (!e.err) begin
              cur_code = e.code;
              cur_mk   = e.mk;
              cur_ex   = e.ex;
            end
          end
        end
        check("code", code, cur_code);
        check("make", make, cur_mk);
        check("ext", ext, cur_ex);
      end
    end
  endtask

  initial begin
    model_reset();
    fork
      compare_loop();
    join_none
    tick(4);
    reset = 1'b0;
    tick(1);
    check("rst_kstb", kstb, 1'b0);
    check("rst_perr", perr, 1'b0);
    check("rst_code", code, 8'h00);
    check("rst_make", make, 1'b1);
    check("rst_ext", ext, 1'b0);
    tick(20);

    send_frame(8'h1C, 1'b0);
    check("lit_1c_code", code, 8'h1C);
    check("lit_1c_make", make, 1'b0);

    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("lit_brk_make", make, 1'b1);

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("lit_75_code", code, 8'h75);
    check("lit_75_make", make, 1'b1);
    check("lit_75_ext", ext, 1'b1);

    send_frame(8'h1C, 1'b1);
    send_frame(8'h29, 1'b0);
    check("lit_29_code", code, 8'h29);
    check("lit_29_make", make, 1'b0);

    // Partial frame abandoned by timeout.
    send_bits(11'b000_0000_1010, 4);
    ps2d = 1'b1;
    tick(2 * (TIMEOUT + 5));
    send_frame(8'h5A, 1'b0);
    check("lit_5a_code", code, 8'h5A);

    // Partial frame abandoned by reset.
    send_bits(11'b000_0000_1010, 4);
    reset = 1'b1;
    model_reset();
    tick(2);
    reset = 1'b0;
    ps2d = 1'b1;
    tick(40);
    send_frame(8'h5A, 1'b0);
    check("lit_5a_rst_code", code, 8'h5A);
    check("lit_5a_rst_make", make, 1'b0);

    send_frame(8'hE1, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'h77, 1'b0);
    send_frame(8'hE1, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h77, 1'b0);
    check("lit_pause_code", code, 8'h5A);
    send_frame(8'h16, 1'b0);
    check("lit_16_code", code, 8'h16);
    check("lit_16_make", make, 1'b0);

    // Short low glitch on the clock with data low must not start a frame.
    ps2d = 1'b0;
    ps2ck = 1'b0;
    tick(2 * (FILTER - 1) - 1);
    ps2ck = 1'b1;
    tick(60);
    ps2d = 1'b1;
    tick(20);
    send_frame(8'h1A, 1'b0);
    check("lit_1a_code", code, 8'h1A);

    send_frame(8'hFA, 1'b0);
    send_frame(8'hAA, 1'b0);
    check("lit_ack_code", code, 8'h1A);

    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
